// File: rtl/chiplib_dispatch_pkg.sv
// Elaboration helpers for the dispatch tree: level count, per-level slot counts,
// group sizing (last group holds the remainder) and per-level destination digits.
package chiplib_dispatch_pkg;

  function automatic int unsigned pow_int(input int unsigned base, input int unsigned power);
    int unsigned acc;
    acc = 1;
    for (int unsigned i = 0; i < power; i++) acc = acc * base;
    return acc;
  endfunction

  function automatic int unsigned num_levels(input int unsigned n, input int unsigned r);
    int unsigned cnt;
    int unsigned lv;
    cnt = n;
    lv  = 1;
    while (cnt > r) begin
      cnt = (cnt + r - 1) / r;
      lv++;
    end
    return lv;
  endfunction

  // Number of registered slots at the output of a given level (root = level 0).
  function automatic int unsigned level_slots(input int unsigned n, input int unsigned r,
                                              input int unsigned level);
    int unsigned span;
    span = pow_int(r, num_levels(n, r) - 1 - level);
    return (n + span - 1) / span;
  endfunction

  function automatic int unsigned slots_before(input int unsigned n, input int unsigned r,
                                               input int unsigned level);
    int unsigned sum;
    sum = 0;
    for (int unsigned m = 0; m < level; m++) sum += level_slots(n, r, m);
    return sum;
  endfunction

  function automatic int unsigned group_size(input int unsigned n, input int unsigned r,
                                             input int unsigned i);
    return ((i + 1) * r <= n) ? r : n - i * r;
  endfunction

  function automatic int unsigned dest_digit(input int unsigned dest, input int unsigned level,
                                             input int unsigned n, input int unsigned r);
    return (dest / pow_int(r, num_levels(n, r) - 1 - level)) % r;
  endfunction

endpackage

// File: rtl/chiplib_dispatch_pri_pipe_if.sv
// Item-in bundle for the dispatcher: valid-only, no backpressure.
interface chiplib_dispatch_pri_pipe_if #(
  parameter int unsigned DestWidth     = 5,
  parameter int unsigned PriorityWidth = 3,
  parameter int unsigned PayloadWidth  = 30
);
  logic                     in_valid;
  logic [DestWidth-1:0]     in_dest;
  logic [PriorityWidth-1:0] in_pri;
  logic [PayloadWidth-1:0]  in_payload;

  modport master (output in_valid, in_dest, in_pri, in_payload);
  modport slave  (input  in_valid, in_dest, in_pri, in_payload);
endinterface

// File: rtl/chiplib_dispatch_pri_pipe_node.sv
// One registered 1-to-NumOut demux stage: per-child valid flop plus a data flop
// that loads only when that child is selected.
module chiplib_dispatch_pri_pipe_node #(
  parameter int unsigned NumOut    = 2,
  parameter int unsigned SelWidth  = 1,
  parameter int unsigned DataWidth = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  input  logic [SelWidth-1:0]              i_sel,
  input  logic [DataWidth-1:0]             i_data,
  output logic [NumOut-1:0]                o_valid,
  output logic [NumOut-1:0][DataWidth-1:0] o_data
);
  logic [NumOut-1:0]                w_hit;
  logic [NumOut-1:0]                r_valid;
  logic [NumOut-1:0][DataWidth-1:0] r_data;

  always_comb begin
    w_hit = '0;
    for (int unsigned c = 0; c < NumOut; c++) w_hit[c] = i_valid && (i_sel == SelWidth'(c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= '0;
    else        r_valid <= w_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      for (int unsigned c = 0; c < NumOut; c++) begin
        if (w_hit[c]) r_data[c] <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/chiplib_dispatch_pri_pipe.sv
// Pipelined 1-to-NumDst dispatcher: a radix-Radix tree of registered demux stages routes each
// tagged item to its destination port; illegal destinations are dropped at the root and counted.
module chiplib_dispatch_pri_pipe
  import chiplib_dispatch_pkg::*;
#(
  parameter  int unsigned NumDst        = 20,
  parameter  int unsigned NumPriorities = 5,
  parameter  int unsigned PayloadWidth  = 30,
  parameter  int unsigned Radix         = 6,
  localparam int unsigned DestWidth     = (NumDst > 1) ? $clog2(NumDst) : 1,
  localparam int unsigned PriorityWidth = (NumPriorities > 1) ? $clog2(NumPriorities) : 1,
  localparam int unsigned Latency       = num_levels(NumDst, Radix)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  chiplib_dispatch_pri_pipe_if.slave           in_if,
  output logic [NumDst-1:0]                    out_valid,
  output logic [NumDst-1:0][PriorityWidth-1:0] out_pri,
  output logic [NumDst-1:0][PayloadWidth-1:0]  out_payload,
  output logic                                 err_bad_dest,
  output logic [7:0]                           drop_count
);
  localparam int unsigned ItemWidth  = PriorityWidth + PayloadWidth;
  localparam int unsigned MidWidth   = DestWidth + ItemWidth;
  localparam int unsigned SelWidth   = $clog2(Radix);
  localparam int unsigned CmpWidth   = DestWidth + 1;
  localparam int unsigned TotalSlots = slots_before(NumDst, Radix, Latency);
  localparam int unsigned LeafOffV   = TotalSlots - NumDst;
  localparam int unsigned LeafOffD   = LeafOffV * MidWidth;
  localparam int unsigned TotalData  = LeafOffD + NumDst * ItemWidth;

  // All tree slots, level by level; inner slots carry {dest, pri, payload}, leaves {pri, payload}.
  logic [TotalSlots-1:0] w_valid;
  logic [TotalData-1:0]  w_data;
  logic                  w_bad_dest;
  logic                  w_accept;
  logic                  r_err_bad_dest;
  logic [7:0]            r_drop_count;

  assign w_bad_dest = in_if.in_valid && ({1'b0, in_if.in_dest} >= CmpWidth'(NumDst));
  assign w_accept   = in_if.in_valid && !w_bad_dest;

  for (genvar k = 0; k < Latency; k++) begin : g_lvl
    localparam int unsigned NumNodes = (k == 0) ? 1 : level_slots(NumDst, Radix, k - 1);
    localparam int unsigned SlotW    = (k == Latency - 1) ? ItemWidth : MidWidth;
    localparam int unsigned OffV     = slots_before(NumDst, Radix, k);
    localparam int unsigned OffD     = OffV * MidWidth;

    for (genvar j = 0; j < NumNodes; j++) begin : g_node
      localparam int unsigned NumChild = group_size(level_slots(NumDst, Radix, k), Radix, j);
      logic                 w_src_valid;
      logic [DestWidth-1:0] w_src_dest;
      logic [ItemWidth-1:0] w_src_item;
      logic [SelWidth-1:0]  w_sel;
      logic [SlotW-1:0]     w_node_data;

      if (k == 0) begin : g_root
        assign w_src_valid = w_accept;
        assign w_src_dest  = in_if.in_dest;
        assign w_src_item  = {in_if.in_pri, in_if.in_payload};
      end else begin : g_inner
        localparam int unsigned PrevOffV = slots_before(NumDst, Radix, k - 1);
        assign w_src_valid              = w_valid[PrevOffV + j];
        assign {w_src_dest, w_src_item} = w_data[PrevOffV * MidWidth + j * MidWidth +: MidWidth];
      end

      // Leaves no longer need the destination, so it is stripped at the last stage.
      if (k == Latency - 1) begin : g_leaf
        assign w_node_data = w_src_item;
      end else begin : g_mid
        assign w_node_data = {w_src_dest, w_src_item};
      end

      assign w_sel = SelWidth'(dest_digit(32'(w_src_dest), k, NumDst, Radix));

      chiplib_dispatch_pri_pipe_node #(
        .NumOut   (NumChild),
        .SelWidth (SelWidth),
        .DataWidth(SlotW)
      ) u_node (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(w_src_valid),
        .i_sel  (w_sel),
        .i_data (w_node_data),
        .o_valid(w_valid[OffV + j * Radix +: NumChild]),
        .o_data (w_data[OffD + j * Radix * SlotW +: NumChild * SlotW])
      );
    end
  end

  assign out_valid = w_valid[LeafOffV +: NumDst];
  for (genvar d = 0; d < NumDst; d++) begin : g_out
    assign {out_pri[d], out_payload[d]} = w_data[LeafOffD + d * ItemWidth +: ItemWidth];
  end

  // Sticky error flag and saturating drop counter for illegal destinations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_bad_dest <= 1'b0;
      r_drop_count   <= '0;
    end else if (w_bad_dest) begin
      r_err_bad_dest <= 1'b1;
      if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign err_bad_dest = r_err_bad_dest;
  assign drop_count   = r_drop_count;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_valid));
  a_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(out_valid));
endmodule
